adc_sum_sq_acc: RTL

ADC_SUM_SQ_ACC -- requirements
Module: adc_sum_sq_acc

---
 rtl/adc_sum_sq_pkg.sv | 20 ++
 rtl/adc_sq_lane.sv | 31 +++
 rtl/adc_sum_sq_acc.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/adc_sum_sq_pkg.sv
// Shared definitions for the ADC sum-of-squares accumulator.
// Holds the lane geometry, the arithmetic widths and the accumulator state enum.
// The largest legal window (2^MAX_LEN_LOG2 beats) sets EXT_W. EXT_W is the width
// the dump is widened to before it is compared against the 32-bit output range.
package adc_sum_sq_pkg;

    localparam int SAMPLE_W     = 8;
    localparam int LANES        = 4;
    localparam int SQ_W         = 16;
    localparam int SUM_W        = 17;
    localparam int MAX_LEN_LOG2 = 24;
    localparam int EXT_W        = SUM_W + MAX_LEN_LOG2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_e;

endpackage

// File: rtl/adc_sq_lane.sv
// One lane of the squaring stage: a signed 8-bit sample in, a registered
// unsigned 16-bit square out.
// Ports:
//   clk      - rising-edge clock
//   sample_i - signed sample, already registered by the caller
//   sq_o     - registered square, exact for -128 (16384)
// This block has no reset. It carries data only, and the valid flags that
// qualify it live in the parent.
module adc_sq_lane
    import adc_sum_sq_pkg::*;
(
    input  logic                       clk,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    output logic        [SQ_W-1:0]     sq_o
);

    logic signed [SQ_W-1:0] prod;
    logic        [SQ_W-1:0] sq_q;

    // A signed 8x8 product fits a signed 16-bit result. The most positive value,
    // (-128)^2 = 16384, is still below 2^15, so reading the result as unsigned
    // is exact.
    assign prod = sample_i * sample_i;

    always_ff @(posedge clk) begin
        sq_q <= $unsigned(prod);
    end

    assign sq_o = sq_q;

endmodule

// File: rtl/adc_sum_sq_acc.sv
// Windowed sum of squares over four packed signed 8-bit ADC lanes.
// Ports:
//   user_clk      - sole clock, rising edge
//   user_rst      - synchronous active-high reset
//   adc_data      - four signed samples per beat, lane 0 in [7:0]
//   adc_valid     - beat qualifier
//   sync_in       - window restart, qualified by adc_valid
//   en            - software enable; low forces IDLE and clears the partial window
//   user_data_out - last completed window sum
//   dump_valid    - one-cycle strobe when user_data_out updates
//   sat_flag      - the last dump exceeded 32 bits (only with ADC_SUM_SQ_SAT_EN)
// Optional feature: define ADC_SUM_SQ_SAT_EN to saturate dumps above 2^32-1.
// Without it, the low 32 bits are kept.
// Latency: the final beat of a window presented in cycle c gives dump_valid in c+4.
module adc_sum_sq_acc
    import adc_sum_sq_pkg::*;
#(
    parameter int ACC_LEN_LOG2 = 16
) (
    input  logic        user_clk,
    input  logic        user_rst,
    input  logic [31:0] adc_data,
    input  logic        adc_valid,
    input  logic        sync_in,
    input  logic        en,
    output logic [31:0] user_data_out,
    output logic        dump_valid,
    output logic        sat_flag
);

    localparam int ACC_W = SUM_W + ACC_LEN_LOG2;
    localparam int CNT_W = ACC_LEN_LOG2;

    // Returns {sat, data} for a completed window value.
    function automatic logic [32:0] shape_dump(input logic [ACC_W-1:0] v);
`ifdef ADC_SUM_SQ_SAT_EN
        if (EXT_W'(v) > EXT_W'(33'h0_FFFF_FFFF))
            return {1'b1, 32'hFFFF_FFFF};
        else
            return {1'b0, 32'(v)};
`else
        return {1'b0, 32'(v)};
`endif
    endfunction

    logic [31:0]      data_p1_q;
    logic             vld_p1_q, sync_p1_q;
    logic [SQ_W-1:0]  sq_p2 [LANES];
    logic             vld_p2_q, sync_p2_q;
    logic [SUM_W-1:0] sum_p3_d, sum_p3_q;
    logic             vld_p3_q, sync_p3_q;

    state_e           state_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [32:0]      dump_shaped;

    // ---- stage 1: input register ----
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            vld_p1_q  <= 1'b0;
            sync_p1_q <= 1'b0;
        end else begin
            vld_p1_q  <= adc_valid;
            sync_p1_q <= adc_valid & sync_in;
        end
    end

    always_ff @(posedge user_clk) begin
        data_p1_q <= adc_data;
    end

    // ---- stage 2: per-lane squares ----
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        adc_sq_lane u_lane (
            .clk      (user_clk),
            .sample_i (data_p1_q[i*SAMPLE_W +: SAMPLE_W]),
            .sq_o     (sq_p2[i])
        );
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            vld_p2_q  <= 1'b0;
            sync_p2_q <= 1'b0;
        end else begin
            vld_p2_q  <= vld_p1_q;
            sync_p2_q <= sync_p1_q;
        end
    end

    // ---- stage 3: lane sum ----
    always_comb begin
        sum_p3_d = '0;
        for (int i = 0; i < LANES; i++)
            sum_p3_d = sum_p3_d + SUM_W'(sq_p2[i]);
    end

    always_ff @(posedge user_clk) begin
        sum_p3_q <= sum_p3_d;
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            vld_p3_q  <= 1'b0;
            sync_p3_q <= 1'b0;
        end else begin
            vld_p3_q  <= vld_p2_q;
            sync_p3_q <= sync_p2_q;
        end
    end

    // ---- stage 4: accumulate / dump ----
    // acc_d includes the current beat, so on the final beat it is the dump value.
    assign acc_d       = acc_q + ACC_W'(sum_p3_q);
    assign dump_shaped = shape_dump(acc_d);

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            user_data_out <= '0;
            dump_valid    <= 1'b0;
            sat_flag      <= 1'b0;
        end else begin
            dump_valid <= 1'b0;
            if (!en) begin
                state_q <= IDLE;
                acc_q   <= '0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: state_q <= ARMED;
                    ARMED: begin
                        if (vld_p3_q && sync_p3_q) begin
                            state_q <= RUN;
                            acc_q   <= ACC_W'(sum_p3_q);
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    RUN: begin
                        if (vld_p3_q) begin
                            // A sync beat restarts the window even on the final index.
                            if (sync_p3_q) begin
                                acc_q <= ACC_W'(sum_p3_q);
                                cnt_q <= CNT_W'(1);
                            end else if (cnt_q == '1) begin
                                user_data_out <= dump_shaped[31:0];
                                sat_flag      <= dump_shaped[32];
                                dump_valid    <= 1'b1;
                                acc_q         <= '0;
                                cnt_q         <= '0;
                            end else begin
                                acc_q <= acc_d;
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
